// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-bus arbiter.
package bus_arbiter_pkg;

  localparam int REG_BUS_W        = 32;  // data bus width (RegBus)
  localparam int INST_ADDR_W      = 32;  // address bus width (InstAddrBus)
  localparam int SEL_W            = 4;
  localparam int RUN_CNT_W        = 4;   // holds MAX_DATA_RUN up to 15
  localparam int TMO_CNT_W        = 8;   // holds TIMEOUT_CYC up to 255
  localparam int DEF_MAX_DATA_RUN = 4;
  localparam int DEF_TIMEOUT_CYC  = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_IF  = 2'd1,
    ST_BUSY_MEM = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  // Command latched from the winner at grant; drives the bus unchanged until done.
  typedef struct packed {
    logic                   we;
    logic [INST_ADDR_W-1:0] addr;
    logic [SEL_W-1:0]       sel;
    logic [REG_BUS_W-1:0]   wdata;
  } bus_cmd_t;

  function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v,
                                                   input logic [RUN_CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Core-side request/ack signals and SoC-side bus signals of the arbiter.
// master: the arbiter itself. slave: the surrounding core + memory.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic                   if_req_i;
  logic [INST_ADDR_W-1:0] if_addr_i;
  logic [REG_BUS_W-1:0]   if_rdata_o;
  logic                   if_ack_o;

  logic                   mem_req_i;
  logic                   mem_we_i;
  logic [INST_ADDR_W-1:0] mem_addr_i;
  logic [SEL_W-1:0]       mem_sel_i;
  logic [REG_BUS_W-1:0]   mem_wdata_i;
  logic [REG_BUS_W-1:0]   mem_rdata_o;
  logic                   mem_ack_o;

  logic                   bus_req_o;
  logic                   bus_we_o;
  logic [INST_ADDR_W-1:0] bus_addr_o;
  logic [SEL_W-1:0]       bus_sel_o;
  logic [REG_BUS_W-1:0]   bus_wdata_o;
  logic [REG_BUS_W-1:0]   bus_rdata_i;
  logic                   bus_ack_i;

  logic                   err_o;
  logic                   stallreq_o;

  modport master (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
    input  bus_rdata_i, bus_ack_i,
    output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    output err_o, stallreq_o
  );

  modport slave (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
    output bus_rdata_i, bus_ack_i,
    input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
    input  err_o, stallreq_o
  );

endinterface

// File: rtl/bus_arb_timer.sv
// Bus timeout timer: loaded on every grant, counts down while a transaction
// is outstanding, and flags expiry on the last allowed wait cycle.
module bus_arb_timer
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [TMO_CNT_W-1:0] LOAD_VAL = TMO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on grant, otherwise count down to zero while busy.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/bus_arbiter.sv
// Shares one req/ack memory bus between instruction fetch and data access.
// Data normally wins; fetch is forced after MAX_DATA_RUN back-to-back data
// grants while it waits. One transaction at a time, aborted after TIMEOUT_CYC.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_IDLE     | arbitrate between pending requests
//   ST_BUSY_IF  | fetch owns the bus, waiting for bus_ack_i
//   ST_BUSY_MEM | data owns the bus, waiting for bus_ack_i
//   ST_RESP     | one-cycle ack (plus rdata/err) to the winner
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master arb
);

  localparam logic [RUN_CNT_W-1:0] RUN_MAX = RUN_CNT_W'(MAX_DATA_RUN);

  arb_state_e             state_q, state_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  bus_cmd_t               cmd_q, cmd_d;
  logic                   bus_req_q, bus_req_d;
  logic                   if_ack_q, if_ack_d;
  logic                   mem_ack_q, mem_ack_d;
  logic [REG_BUS_W-1:0]   rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   grant;
  logic                   busy;
  logic                   tmo_expire;
  logic                   fetch_starved;

  assign busy          = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_MEM);
  assign fetch_starved = arb.if_req_i && (run_cnt_q == RUN_MAX);

  bus_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (grant),
    .run_i    (busy),
    .expire_o (tmo_expire)
  );

  // Arbitration, transaction sequencing and response generation.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    cmd_d     = cmd_q;
    bus_req_d = bus_req_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    if_ack_d  = 1'b0;
    mem_ack_d = 1'b0;
    grant     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb.mem_req_i && !fetch_starved) begin
          state_d   = ST_BUSY_MEM;
          grant     = 1'b1;
          bus_req_d = 1'b1;
          cmd_d     = '{we: arb.mem_we_i, addr: arb.mem_addr_i,
                        sel: arb.mem_sel_i, wdata: arb.mem_wdata_i};
          run_cnt_d = arb.if_req_i ? sat_inc(run_cnt_q, RUN_MAX) : '0;
        end else if (arb.if_req_i) begin
          state_d   = ST_BUSY_IF;
          grant     = 1'b1;
          bus_req_d = 1'b1;
          cmd_d     = '{we: 1'b0, addr: arb.if_addr_i, sel: 4'hF, wdata: '0};
          run_cnt_d = '0;
        end
      end
      ST_BUSY_IF, ST_BUSY_MEM: begin
        if (arb.bus_ack_i) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          rdata_d   = arb.bus_rdata_i;
          err_d     = 1'b0;
          if_ack_d  = (state_q == ST_BUSY_IF);
          mem_ack_d = (state_q == ST_BUSY_MEM);
        end else if (tmo_expire) begin
          state_d   = ST_RESP;
          bus_req_d = 1'b0;
          rdata_d   = '0;
          err_d     = 1'b1;
          if_ack_d  = (state_q == ST_BUSY_IF);
          mem_ack_d = (state_q == ST_BUSY_MEM);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
      cmd_q     <= '0;
      bus_req_q <= 1'b0;
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      cmd_q     <= cmd_d;
      bus_req_q <= bus_req_d;
      if_ack_q  <= if_ack_d;
      mem_ack_q <= mem_ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign arb.bus_req_o   = bus_req_q;
  assign arb.bus_we_o    = cmd_q.we;
  assign arb.bus_addr_o  = cmd_q.addr;
  assign arb.bus_sel_o   = cmd_q.sel;
  assign arb.bus_wdata_o = cmd_q.wdata;
  assign arb.if_ack_o    = if_ack_q;
  assign arb.mem_ack_o   = mem_ack_q;
  assign arb.if_rdata_o  = rdata_q;
  assign arb.mem_rdata_o = rdata_q;
  assign arb.err_o       = err_q;
  assign arb.stallreq_o  = (arb.if_req_i && !if_ack_q) || (arb.mem_req_i && !mem_ack_q);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int MAX_RUN = 4;
  localparam int TMO     = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_arbiter_if bif();

  bus_arbiter #(.MAX_DATA_RUN(MAX_RUN), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bif)
  );

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          len;
    logic        pend_if;
    logic        pend_mem;
    logic [31:0] if_addr;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_wdata;
  } txn_t;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  txn_t        bus_log[$];
  ack_t        ack_log[$];
  logic [31:0] slave_q[$];
  int          changed_cnt, dbl_ack_cnt;

  // slave behaviour controls
  int          slave_lat = 0;      // -1: never acks
  bit          slave_rand_lat = 0;
  bit          slave_fixed_en = 0;
  logic [31:0] slave_fixed_data = '0;
  int          spur_cnt = 0;
  int          cur_lat, wait_cnt;

  bit done_if, done_mem;

  // monitor state
  logic        prev_req = 1'b0;
  logic        p_if, p_mem, p_mwe;
  logic [31:0] p_if_addr, p_maddr, p_mwdata;
  logic [3:0]  p_msel;
  txn_t        cur;

  // Bus monitor: records each bus transaction with the requests visible at its grant edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bif.bus_req_o === 1'b1) begin
        if (!prev_req) begin
          cur.we = bif.bus_we_o; cur.addr = bif.bus_addr_o;
          cur.sel = bif.bus_sel_o; cur.wdata = bif.bus_wdata_o; cur.len = 1;
          cur.pend_if = p_if; cur.pend_mem = p_mem; cur.if_addr = p_if_addr;
          cur.m_we = p_mwe; cur.m_addr = p_maddr; cur.m_sel = p_msel; cur.m_wdata = p_mwdata;
        end else begin
          cur.len++;
          if ({bif.bus_we_o, bif.bus_addr_o, bif.bus_sel_o, bif.bus_wdata_o} !==
              {cur.we, cur.addr, cur.sel, cur.wdata}) changed_cnt++;
        end
      end else if (prev_req) begin
        bus_log.push_back(cur);
      end
      prev_req = (bif.bus_req_o === 1'b1);
      if (bif.if_ack_o === 1'b1 && bif.mem_ack_o === 1'b1) dbl_ack_cnt++;
      if (bif.if_ack_o === 1'b1 || bif.mem_ack_o === 1'b1)
        ack_log.push_back('{is_mem: bif.mem_ack_o,
                            rdata: (bif.mem_ack_o === 1'b1) ? bif.mem_rdata_o : bif.if_rdata_o,
                            err: bif.err_o});
      p_if = bif.if_req_i; p_mem = bif.mem_req_i; p_if_addr = bif.if_addr_i;
      p_mwe = bif.mem_we_i; p_maddr = bif.mem_addr_i; p_msel = bif.mem_sel_i;
      p_mwdata = bif.mem_wdata_i;
    end
  end

  // Memory slave model.
  initial begin
    bif.bus_ack_i = 1'b0;
    bif.bus_rdata_i = '0;
    wait_cnt = 0;
    cur_lat = 0;
    forever begin
      @(negedge clk);
      if (spur_cnt > 0) begin
        bif.bus_ack_i = 1'b1;
        bif.bus_rdata_i = $urandom;
        spur_cnt--;
      end else if (bif.bus_ack_i) begin
        bif.bus_ack_i = 1'b0;
        wait_cnt = 0;
      end else if (bif.bus_req_o === 1'b1) begin
        if (wait_cnt == 0) cur_lat = slave_rand_lat ? int'($urandom_range(3, 0)) : slave_lat;
        if (cur_lat >= 0 && wait_cnt >= cur_lat) begin
          bif.bus_ack_i = 1'b1;
          bif.bus_rdata_i = slave_fixed_en ? slave_fixed_data : $urandom;
          slave_q.push_back(bif.bus_rdata_i);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    bif.if_req_i = 0; bif.if_addr_i = '0;
    bif.mem_req_i = 0; bif.mem_we_i = 0; bif.mem_addr_i = '0;
    bif.mem_sel_i = '0; bif.mem_wdata_i = '0;
  endtask

  task automatic apply_reset();
    clear_req();
    slave_lat = 0; slave_rand_lat = 0; slave_fixed_en = 0; spur_cnt = 0;
    #2 rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    bus_log.delete(); ack_log.delete(); slave_q.delete();
    changed_cnt = 0; dbl_ack_cnt = 0;
  endtask

  // Waits (bounded) for the chosen requester's ack; leaves time at that ack's negedge.
  task automatic wait_ack(input bit want_mem, output bit got, output int lat,
                          output int stall_bad, output bit other);
    got = 0; lat = 0; stall_bad = 0; other = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if ((want_mem ? bif.mem_ack_o : bif.if_ack_o) === 1'b1) got = 1;
      else if (bif.stallreq_o !== 1'b1) stall_bad++;
      if ((want_mem ? bif.if_ack_o : bif.mem_ack_o) === 1'b1) other = 1;
    end
  endtask

  task automatic test_reset();
    clear_req();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o} !== '0) begin
      n_fails++; $display("FAIL reset_bus: got req=%b we=%b sel=%h addr=%h wdata=%h expected all 0",
        bif.bus_req_o, bif.bus_we_o, bif.bus_sel_o, bif.bus_addr_o, bif.bus_wdata_o);
    end
    n_checks++;
    if ({bif.if_ack_o, bif.mem_ack_o, bif.err_o, bif.stallreq_o} !== 4'b0000) begin
      n_fails++; $display("FAIL reset_ack: got if_ack=%b mem_ack=%b err=%b stall=%b expected 0000",
        bif.if_ack_o, bif.mem_ack_o, bif.err_o, bif.stallreq_o);
    end
    n_checks++;
    if ({bif.if_rdata_o, bif.mem_rdata_o} !== 64'h0) begin
      n_fails++; $display("FAIL reset_rdata: got %h/%h expected 0", bif.if_rdata_o, bif.mem_rdata_o);
    end
    bif.if_req_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bif.stallreq_o !== 1'b1) begin
      n_fails++; $display("FAIL reset_stall_comb: got %b expected 1", bif.stallreq_o);
    end
    n_checks++;
    if (bif.bus_req_o !== 1'b0) begin
      n_fails++; $display("FAIL reset_no_grant: got bus_req=%b expected 0", bif.bus_req_o);
    end
    clear_req();
  endtask

  task automatic test_fetch_only();
    bit got, other; int lat, sb;
    apply_reset();
    slave_fixed_en = 1; slave_fixed_data = 32'h3C010001;
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h100;
    wait_ack(1'b0, got, lat, sb, other);
    n_checks++;
    if (got !== 1'b1) begin n_fails++; $display("FAIL fetch_ack_seen: got %b expected 1", got); end
    if (got) begin
      n_checks++;
      if (bif.if_rdata_o !== 32'h3C010001) begin
        n_fails++; $display("FAIL fetch_rdata: got %h expected 3c010001", bif.if_rdata_o);
      end
      n_checks++;
      if ({bif.err_o, bif.mem_ack_o, bif.stallreq_o} !== 3'b000) begin
        n_fails++; $display("FAIL fetch_ack_cycle: got err=%b mem_ack=%b stall=%b expected 000",
          bif.err_o, bif.mem_ack_o, bif.stallreq_o);
      end
    end
    n_checks++;
    if (lat != 3) begin n_fails++; $display("FAIL fetch_latency: got %0d expected 3", lat); end
    n_checks++;
    if (sb != 0) begin n_fails++; $display("FAIL fetch_stall: %0d cycles low expected 0", sb); end
    step();
    bif.if_req_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bif.if_ack_o !== 1'b0) begin n_fails++; $display("FAIL fetch_ack_pulse: got %b expected 0", bif.if_ack_o); end
    n_checks++;
    if (bus_log.size() != 1) begin
      n_fails++; $display("FAIL fetch_txn_count: got %0d expected 1", bus_log.size());
    end else begin
      n_checks++;
      if ({bus_log[0].we, bus_log[0].sel, bus_log[0].addr, bus_log[0].wdata, bus_log[0].len} !==
          {1'b0, 4'hF, 32'h100, 32'h0, 32'd1}) begin
        n_fails++; $display("FAIL fetch_bus_fields: got we=%b sel=%h addr=%h wdata=%h len=%0d expected 0/f/100/0/1",
          bus_log[0].we, bus_log[0].sel, bus_log[0].addr, bus_log[0].wdata, bus_log[0].len);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit if_done, mem_done; int if_pos, mem_pos, ord, cyc;
    apply_reset();
    slave_rand_lat = 1;
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h180;
    bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b1; bif.mem_addr_i = 32'h200;
    bif.mem_sel_i = 4'b0011; bif.mem_wdata_i = 32'hDEADBEEF;
    if_done = 0; mem_done = 0; ord = 0; cyc = 0; if_pos = -1; mem_pos = -1;
    while ((!if_done || !mem_done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bif.mem_ack_o === 1'b1) begin mem_done = 1; mem_pos = ord++; end
      if (bif.if_ack_o === 1'b1) begin if_done = 1; if_pos = ord++; end
      step();
      if (mem_done) bif.mem_req_i = 1'b0;
      if (if_done) bif.if_req_i = 1'b0;
    end
    n_checks++;
    if ({mem_pos, if_pos} !== {32'd0, 32'd1}) begin
      n_fails++; $display("FAIL simul_order: got mem_pos=%0d if_pos=%0d expected 0 1", mem_pos, if_pos);
    end
    n_checks++;
    if (bus_log.size() != 2 || ack_log.size() != 2 || slave_q.size() != 2) begin
      n_fails++; $display("FAIL simul_counts: got txn=%0d ack=%0d slave=%0d expected 2 2 2",
        bus_log.size(), ack_log.size(), slave_q.size());
    end else begin
      n_checks++;
      if ({bus_log[0].we, bus_log[0].addr, bus_log[0].sel, bus_log[0].wdata} !==
          {1'b1, 32'h200, 4'b0011, 32'hDEADBEEF}) begin
        n_fails++; $display("FAIL simul_write_fields: got we=%b addr=%h sel=%h wdata=%h expected 1/200/3/deadbeef",
          bus_log[0].we, bus_log[0].addr, bus_log[0].sel, bus_log[0].wdata);
      end
      n_checks++;
      if ({bus_log[1].we, bus_log[1].addr, bus_log[1].sel, bus_log[1].wdata} !==
          {1'b0, 32'h180, 4'hF, 32'h0}) begin
        n_fails++; $display("FAIL simul_fetch_fields: got we=%b addr=%h sel=%h wdata=%h expected 0/180/f/0",
          bus_log[1].we, bus_log[1].addr, bus_log[1].sel, bus_log[1].wdata);
      end
      n_checks++;
      if (ack_log[1].rdata !== slave_q[1]) begin
        n_fails++; $display("FAIL simul_fetch_rdata: got %h expected %h", ack_log[1].rdata, slave_q[1]);
      end
    end
    n_checks++;
    if (changed_cnt != 0) begin n_fails++; $display("FAIL simul_bus_stable: got %0d changes expected 0", changed_cnt); end
  endtask

  task automatic test_starvation();
    int n_acks, cyc; bit ma, ia;
    logic [9:0] got_bus, got_ack, exp_kind;
    apply_reset();
    slave_rand_lat = 1;
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h400;
    bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b0; bif.mem_addr_i = 32'h8000; bif.mem_sel_i = 4'h1;
    n_acks = 0; cyc = 0;
    while (n_acks < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      ma = (bif.mem_ack_o === 1'b1); ia = (bif.if_ack_o === 1'b1);
      n_acks += int'(ma) + int'(ia);
      step();
      if (ma) bif.mem_addr_i += 4;
      if (ia) bif.if_addr_i += 4;
      if (n_acks >= 10) clear_req();
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) exp_kind[i] = ((i % (MAX_RUN + 1)) == MAX_RUN);
    got_bus = '1; got_ack = '1;
    for (int i = 0; i < 10 && i < bus_log.size(); i++) got_bus[i] = ~bus_log[i].addr[15];
    for (int i = 0; i < 10 && i < ack_log.size(); i++) got_ack[i] = ~ack_log[i].is_mem;
    n_checks++;
    if (bus_log.size() != 10) begin n_fails++; $display("FAIL starve_txn_count: got %0d expected 10", bus_log.size()); end
    n_checks++;
    if (got_bus !== exp_kind) begin
      n_fails++; $display("FAIL starve_grant_seq: got %b expected %b (1=fetch, bit0 first)", got_bus, exp_kind);
    end
    n_checks++;
    if (got_ack !== exp_kind) begin
      n_fails++; $display("FAIL starve_ack_seq: got %b expected %b", got_ack, exp_kind);
    end
    if (bus_log.size() == 10) begin
      n_checks++;
      if ({bus_log[4].addr, bus_log[9].addr} !== {32'h400, 32'h404}) begin
        n_fails++; $display("FAIL starve_fetch_addr: got %h %h expected 400 404", bus_log[4].addr, bus_log[9].addr);
      end
    end
  endtask

  task automatic test_timeout();
    bit got, other; int lat, sb;
    apply_reset();
    slave_fixed_en = 1; slave_fixed_data = 32'hA5A5A5A5;
    bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b0; bif.mem_addr_i = 32'h300; bif.mem_sel_i = 4'hF;
    wait_ack(1'b1, got, lat, sb, other);
    n_checks++;
    if ({got, bif.mem_rdata_o, bif.err_o} !== {1'b1, 32'hA5A5A5A5, 1'b0}) begin
      n_fails++; $display("FAIL tmo_pre_read: got ack=%b rdata=%h err=%b expected 1/a5a5a5a5/0", got, bif.mem_rdata_o, bif.err_o);
    end
    step();
    slave_lat = -1;
    bif.mem_addr_i = 32'h304;
    wait_ack(1'b1, got, lat, sb, other);
    n_checks++;
    if ({got, bif.mem_rdata_o, bif.err_o} !== {1'b1, 32'h0, 1'b1}) begin
      n_fails++; $display("FAIL tmo_abort: got ack=%b rdata=%h err=%b expected 1/0/1", got, bif.mem_rdata_o, bif.err_o);
    end
    n_checks++;
    if (lat != TMO + 2) begin n_fails++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TMO + 2); end
    n_checks++;
    if ({sb, 31'd0, other} !== 64'd0) begin n_fails++; $display("FAIL tmo_stall_other: got stall_low=%0d other_ack=%b expected 0 0", sb, other); end
    step();
    slave_lat = 0; slave_fixed_data = 32'h12345678;
    bif.mem_addr_i = 32'h308;
    wait_ack(1'b1, got, lat, sb, other);
    n_checks++;
    if ({got, bif.mem_rdata_o, bif.err_o} !== {1'b1, 32'h12345678, 1'b0}) begin
      n_fails++; $display("FAIL tmo_recover: got ack=%b rdata=%h err=%b expected 1/12345678/0", got, bif.mem_rdata_o, bif.err_o);
    end
    step();
    clear_req();
    @(negedge clk);
    n_checks++;
    if (bus_log.size() != 3) begin
      n_fails++; $display("FAIL tmo_txn_count: got %0d expected 3", bus_log.size());
    end else begin
      n_checks++;
      if (bus_log[1].len != TMO) begin n_fails++; $display("FAIL tmo_req_len: got %0d expected %0d", bus_log[1].len, TMO); end
    end
  endtask

  task automatic test_reset_mid();
    bit got, other, up, ack_seen; int lat, sb, cyc;
    apply_reset();
    slave_lat = -1;
    bif.mem_req_i = 1'b1; bif.mem_we_i = 1'b1; bif.mem_addr_i = 32'h500;
    bif.mem_sel_i = 4'hC; bif.mem_wdata_i = 32'hCAFEF00D;
    up = 0; cyc = 0;
    while (!up && cyc < 20) begin
      @(negedge clk); cyc++;
      up = (bif.bus_req_o === 1'b1);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({up, bif.bus_req_o} !== 2'b10) begin
      n_fails++; $display("FAIL rstmid_bus_req: got started=%b bus_req=%b expected 1 0", up, bif.bus_req_o);
    end
    bif.mem_req_i = 1'b0;
    ack_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bif.if_ack_o !== 1'b0 || bif.mem_ack_o !== 1'b0) ack_seen = 1;
    end
    step();
    rst = 1'b1;
    slave_lat = 0; slave_fixed_en = 1; slave_fixed_data = 32'h0BADF00D;
    repeat (2) begin
      @(negedge clk);
      if (bif.if_ack_o !== 1'b0 || bif.mem_ack_o !== 1'b0) ack_seen = 1;
    end
    n_checks++;
    if (ack_seen !== 1'b0) begin n_fails++; $display("FAIL rstmid_no_ack: got ack pulse=%b expected 0", ack_seen); end
    step();
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h600;
    wait_ack(1'b0, got, lat, sb, other);
    n_checks++;
    if ({got, bif.if_rdata_o, bif.err_o, other} !== {1'b1, 32'h0BADF00D, 1'b0, 1'b0}) begin
      n_fails++; $display("FAIL rstmid_fetch: got ack=%b rdata=%h err=%b mem_ack=%b expected 1/0badf00d/0/0",
        got, bif.if_rdata_o, bif.err_o, other);
    end
    n_checks++;
    if (lat != 3) begin n_fails++; $display("FAIL rstmid_latency: got %0d expected 3", lat); end
    step();
    clear_req();
  endtask

  task automatic test_spurious();
    bit got, other; int lat, sb, bad;
    apply_reset();
    slave_fixed_en = 1; slave_fixed_data = 32'h77770001;
    spur_cnt = 3;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if ({bif.if_ack_o, bif.mem_ack_o, bif.bus_req_o} !== 3'b000) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fails++; $display("FAIL spur_reaction: got %0d bad cycles expected 0", bad); end
    step();
    bif.if_req_i = 1'b1; bif.if_addr_i = 32'h700;
    wait_ack(1'b0, got, lat, sb, other);
    n_checks++;
    if ({got, bif.if_rdata_o, lat} !== {1'b1, 32'h77770001, 32'd3}) begin
      n_fails++; $display("FAIL spur_then_fetch: got ack=%b rdata=%h lat=%0d expected 1/77770001/3", got, bif.if_rdata_o, lat);
    end
    step();
    clear_req();
  endtask

  task automatic req_fetch(input int n);
    bit got; int c;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3, 0)) step();
      bif.if_addr_i = $urandom & 32'hFFFF_FFFC;
      bif.if_req_i = 1'b1;
      got = 0; c = 0;
      while (!got && c < 200) begin
        @(negedge clk); c++;
        got = (bif.if_ack_o === 1'b1);
      end
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL rand_fetch_served: got no ack expected ack, req %0d", k); end
      step();
      bif.if_req_i = 1'b0;
    end
    done_if = 1;
  endtask

  task automatic req_mem(input int n);
    bit got; int c;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(3, 0)) step();
      bif.mem_we_i = 1'($urandom);
      bif.mem_addr_i = $urandom;
      bif.mem_sel_i = 4'($urandom_range(15, 1));
      bif.mem_wdata_i = $urandom;
      bif.mem_req_i = 1'b1;
      got = 0; c = 0;
      while (!got && c < 200) begin
        @(negedge clk); c++;
        got = (bif.mem_ack_o === 1'b1);
      end
      n_checks++;
      if (!got) begin n_fails++; $display("FAIL rand_mem_served: got no ack expected ack, req %0d", k); end
      step();
      bif.mem_req_i = 1'b0;
    end
    done_mem = 1;
  endtask

  task automatic test_random();
    int run, stall_bad, cyc, n;
    bit exp_mem;
    logic [68:0] exp_f, got_f;
    apply_reset();
    slave_rand_lat = 1;
    done_if = 0; done_mem = 0; stall_bad = 0;
    fork
      req_fetch(12);
      req_mem(12);
      begin
        cyc = 0;
        while (!(done_if && done_mem) && cyc < 3000) begin
          @(negedge clk); cyc++;
          if (bif.stallreq_o !== ((bif.if_req_i & ~bif.if_ack_o) | (bif.mem_req_i & ~bif.mem_ack_o)))
            stall_bad++;
        end
      end
    join
    repeat (2) @(negedge clk);
    n_checks++;
    if (stall_bad != 0) begin n_fails++; $display("FAIL rand_stallreq: got %0d wrong cycles expected 0", stall_bad); end
    n_checks++;
    if (bus_log.size() != 24 || ack_log.size() != 24 || slave_q.size() != 24) begin
      n_fails++; $display("FAIL rand_counts: got txn=%0d ack=%0d slave=%0d expected 24", bus_log.size(), ack_log.size(), slave_q.size());
    end
    n = bus_log.size();
    if (ack_log.size() < n) n = ack_log.size();
    if (slave_q.size() < n) n = slave_q.size();
    run = 0;
    for (int i = 0; i < n; i++) begin
      exp_mem = bus_log[i].pend_mem && !(bus_log[i].pend_if && run == MAX_RUN);
      exp_f = exp_mem ? {bus_log[i].m_we, bus_log[i].m_addr, bus_log[i].m_sel, bus_log[i].m_wdata}
                      : {1'b0, bus_log[i].if_addr, 4'hF, 32'h0};
      got_f = {bus_log[i].we, bus_log[i].addr, bus_log[i].sel, bus_log[i].wdata};
      n_checks++;
      if (got_f !== exp_f) begin
        n_fails++; $display("FAIL rand_bus_fields[%0d]: got %h expected %h", i, got_f, exp_f);
      end
      n_checks++;
      if ({ack_log[i].is_mem, ack_log[i].rdata, ack_log[i].err} !== {exp_mem, slave_q[i], 1'b0}) begin
        n_fails++; $display("FAIL rand_ack[%0d]: got mem=%b rdata=%h err=%b expected mem=%b rdata=%h err=0",
          i, ack_log[i].is_mem, ack_log[i].rdata, ack_log[i].err, exp_mem, slave_q[i]);
      end
      if (exp_mem) run = bus_log[i].pend_if ? ((run + 1 > MAX_RUN) ? MAX_RUN : run + 1) : 0;
      else run = 0;
    end
    n_checks++;
    if ({changed_cnt, dbl_ack_cnt} !== 64'd0) begin
      n_fails++; $display("FAIL rand_integrity: got bus_changes=%0d double_acks=%0d expected 0 0", changed_cnt, dbl_ack_cnt);
    end
  endtask

  initial begin
    changed_cnt = 0; dbl_ack_cnt = 0;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory bus (single port, req/ack handshake) between the instruction-fetch requester and the data-access (mem stage) requester of the openmips core.
- Sits between the core and the SoC memory.
- Sequences one transaction at a time and latches the winning request.
- Returns read data and ack to the winner.
- Raises a stall request toward the pipeline controller while any requester is waiting.
- Includes a bounded-starvation guarantee for fetch and a bus timeout.

Parameters:
- MAX_DATA_RUN, 4: consecutive data grants allowed while fetch is pending before fetch is forced (range 1..15).
- TIMEOUT_CYC, 255: bus cycles waited for bus_ack_i before aborting (range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req_i  in  1  fetch request, level; held until if_ack_o.
- if_addr_i  in  32  fetch address.
- if_rdata_o  out  32  fetch read data, valid with if_ack_o.
- if_ack_o  out  1  one-cycle completion pulse to fetch.
- mem_req_i  in  1  data request, level; held until mem_ack_o.
- mem_we_i  in  1  1 = write.
- mem_addr_i  in  32  data address.
- mem_sel_i  in  4  byte lane enables.
- mem_wdata_i  in  32  write data.
- mem_rdata_o  out  32  read data, valid with mem_ack_o.
- mem_ack_o  out  1  one-cycle completion pulse to data.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  32  bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_wdata_o  out  32  bus write data.
- bus_rdata_i  in  32  bus read data, valid with bus_ack_i.
- bus_ack_i  in  1  bus completion.
- err_o  out  1  timeout flag, pulses with the aborted transaction's ack.
- stallreq_o  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - All registered outputs clear: bus_* = 0, acks = 0, rdata = 0, err_o = 0.
  - run_cnt = 0, tmo_cnt = 0.
  - A bus transaction in flight is abandoned; bus_req_o falls immediately with reset.
- States:
  - IDLE: arbitration.
  - BUSY_IF: fetch owns the bus.
  - BUSY_MEM: data owns the bus.
  - RESP: one-cycle ack pulse.
- IDLE arbitration, evaluated at the rising edge:
  - mem_req_i=1 and not (if_req_i=1 and run_cnt==MAX_DATA_RUN): go to BUSY_MEM.
  - Otherwise if_req_i=1: go to BUSY_IF.
  - Otherwise stay in IDLE.
- On entry to BUSY_*:
  - Latch we/addr/sel/wdata from the winner; fetch forces we=0, sel=4'hF, wdata=0.
  - Drive bus_* from the latches; the bus never sees mid-transaction changes.
  - bus_req_o=1 on the cycle after the grant edge.
- run_cnt:
  - +1 on a data grant while if_req_i=1, saturating at MAX_DATA_RUN.
  - Cleared on any fetch grant, or on a data grant while if_req_i=0.
- In BUSY_*:
  - tmo_cnt increments each cycle.
  - bus_ack_i=1: capture bus_rdata_i, go to RESP with err=0.
  - Else tmo_cnt==TIMEOUT_CYC-1: go to RESP with err=1 and rdata=0.
  - bus_req_o drops at the same edge in both cases.
- In RESP:
  - The winner's ack_o=1 for exactly one cycle; rdata_o and err_o are valid in that cycle.
  - The non-winner's ack stays 0.
  - Next state is always IDLE; no arbitration in RESP, so a winner whose req drops with ack is never re-granted.
- Minimum latency: request visible at edge N; bus_req_o high at N..N+1; zero-wait ack during N+1; ack_o high in cycle N+2.
- rdata_o and err_o hold their last value outside RESP; the bench checks them only with ack.
- bus_ack_i in IDLE or RESP is ignored (spurious; no state change).
- stallreq_o (combinational) = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
- Simultaneous requests in IDLE: data wins unless the starvation condition holds.
- A request asserted during BUSY_* or RESP waits; it is arbitrated in the next IDLE.

Decomposition:
- Shared define file holds:
  - Arbiter state encodings (2 bits).
  - Bus width macros, reusing RegBus / InstAddrBus.
  - Defaults for MAX_DATA_RUN and TIMEOUT_CYC.
- One natural sub-module: bus_arb_timer, the loadable timeout counter (clear on grant, expire flag).
- Arbitration logic and FSM stay in bus_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: if_req_i=1, if_addr_i=0x100; slave acks 1 cycle after bus_req_o with rdata 0x3C010001.
  - Required: bus_we_o=0, bus_sel_o=F; if_ack_o one cycle with if_rdata_o=0x3C010001; stallreq_o=1 until ack cycle.
- Simultaneous:
  - Stimulus: if_req_i=1 and mem_req_i=1 (store 0xDEADBEEF to 0x200, sel=4'b0011).
  - Required: first bus transaction is the write with those exact fields; fetch transaction follows; mem_ack_o precedes if_ack_o.
- Starvation (MAX_DATA_RUN=4):
  - Stimulus: mem_req_i re-asserted continuously, if_req_i held high.
  - Required: exactly 4 data grants, then 1 fetch grant, then run_cnt back to 0.
- Timeout (TIMEOUT_CYC=8):
  - Stimulus: slave never acks a data read.
  - Required: bus_req_o high exactly 8 cycles; mem_ack_o=1 with err_o=1 and mem_rdata_o=0; next request is served normally.
- Reset mid-transaction:
  - Stimulus: rst=0 while BUSY_MEM.
  - Required: bus_req_o=0 immediately, no ack pulse; after release, a fresh fetch completes with correct data.
- Spurious ack:
  - Stimulus: bus_ack_i=1 in IDLE.
  - Required: no ack_o, state remains IDLE.
